// File: rtl/alu_issue_stage_pkg.sv
// Opcode encodings and compare-class decode shared by the ALU issue stage and the compare unit.
package alu_issue_stage_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_EQ = 4'b0111;
    localparam logic [OP_W-1:0] OP_NE = 4'b1001;
    localparam logic [OP_W-1:0] OP_GT = 4'b1010;
    localparam logic [OP_W-1:0] OP_LT = 4'b1011;
    localparam logic [OP_W-1:0] OP_GE = 4'b1110;
    localparam logic [OP_W-1:0] OP_LE = 4'b1111;

    function automatic logic is_cmp_op(input logic [OP_W-1:0] op);
        logic hit;
        hit = 1'b0;
        case (op)
            OP_EQ, OP_NE, OP_GT, OP_LT, OP_GE, OP_LE: hit = 1'b1;
            default:                                  hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/alu_issue_stage.sv
// Registered issue stage with a 2-entry (main + skid) buffer feeding the compare unit / ALU.
// Latency 1 cycle when main is empty or drains; in_ready is a flop, low only while skid is occupied.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OPW   = OP_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    input  logic [OPW-1:0]   in_op_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [OPW-1:0]   op_sel,
    output logic             is_cmp,
    output logic [CNT_W-1:0] issue_cnt
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [OPW-1:0]   op;
    } pkt_t;

    pkt_t             main_q, main_d;
    pkt_t             skid_q, skid_d;
    pkt_t             in_pkt;
    logic             main_v_q, main_v_d;
    logic             skid_v_q, skid_v_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
    logic             in_fire;
    logic             out_fire;

    assign in_pkt   = '{a: in_A, b: in_B, op: in_op_sel};
    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = main_v_q & out_ready;

    always_comb begin
        main_d      = main_q;
        skid_d      = skid_q;
        main_v_d    = main_v_q;
        skid_v_d    = skid_v_q;
        issue_cnt_d = issue_cnt_q + CNT_W'(out_fire);

        if (flush) begin
            // Data registers keep their stale contents; only the valids are dropped.
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!main_v_q || out_fire) begin
            if (skid_v_q) begin
                main_d   = skid_q;
                main_v_d = 1'b1;
                skid_v_d = in_fire;
                if (in_fire) begin
                    skid_d = in_pkt;
                end
            end else if (in_fire) begin
                main_d   = in_pkt;
                main_v_d = 1'b1;
            end else begin
                main_v_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_d   = in_pkt;
            skid_v_d = 1'b1;
        end

        in_ready_d = !skid_v_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q      <= '0;
            skid_q      <= '0;
            main_v_q    <= 1'b0;
            skid_v_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            issue_cnt_q <= '0;
        end else begin
            main_q      <= main_d;
            skid_q      <= skid_d;
            main_v_q    <= main_v_d;
            skid_v_q    <= skid_v_d;
            in_ready_q  <= in_ready_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_v_q;
    assign A         = main_q.a;
    assign B         = main_q.b;
    assign op_sel    = main_q.op;
    assign is_cmp    = main_v_q & is_cmp_op(main_q.op);
    assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed and scoreboarded checks of the ALU issue stage skid buffer, flush, reset and counter.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_A;
    logic [7:0]  in_B;
    logic [3:0]  in_op_sel;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [3:0]  op_sel;
    logic        is_cmp;
    logic [15:0] issue_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_A      (in_A),
        .in_B      (in_B),
        .in_op_sel (in_op_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .A         (A),
        .B         (B),
        .op_sel    (op_sel),
        .is_cmp    (is_cmp),
        .issue_cnt (issue_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        in_valid  = v;
        in_A      = a;
        in_B      = b;
        in_op_sel = op;
    endtask

    function automatic logic exp_cmp(input logic [3:0] op);
        return (op == 4'h7) || (op == 4'h9) || (op == 4'hA) ||
               (op == 4'hB) || (op == 4'hE) || (op == 4'hF);
    endfunction

    initial begin
        logic [19:0] sb[$];
        logic [19:0] exp_pkt;
        int acc;
        int emit;
        int cyc;

        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 4'h0);

        // Reset
        step();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready",  in_ready, 1);
        chk("rst_cnt",       issue_cnt, 0);
        chk("rst_A",         A, 0);
        chk("rst_B",         B, 0);
        chk("rst_is_cmp",    is_cmp, 0);
        rst = 1'b0;
        step();

        // Pass-through
        out_ready = 1'b1;
        drive(1'b1, 8'd5, 8'd3, 4'b1010);
        step();
        drive(1'b0, 8'h00, 8'h00, 4'h0);
        chk("pt_out_valid", out_valid, 1);
        chk("pt_A",         A, 5);
        chk("pt_B",         B, 3);
        chk("pt_is_cmp",    is_cmp, 1);
        chk("pt_cnt_pre",   issue_cnt, 0);
        step();
        chk("pt_cnt",       issue_cnt, 1);
        chk("pt_drained",   out_valid, 0);

        // Backpressure: P1 held in main, P2 parked in skid
        out_ready = 1'b0;
        drive(1'b1, 8'd1, 8'd2, 4'b0111);
        step();
        chk("bp_ready_p1", in_ready, 1);
        drive(1'b1, 8'd3, 8'd4, 4'b0001);
        step();
        drive(1'b0, 8'h00, 8'h00, 4'h0);
        chk("bp_ready_p2", in_ready, 0);
        chk("bp_hold_A",   A, 1);
        chk("bp_hold_B",   B, 2);
        chk("bp_hold_op",  op_sel, 4'b0111);
        chk("bp_hold_cmp", is_cmp, 1);
        step();
        chk("bp_stable_A", A, 1);
        chk("bp_stable_v", out_valid, 1);
        out_ready = 1'b1;
        step();
        chk("bp_p2_A",     A, 3);
        chk("bp_p2_B",     B, 4);
        chk("bp_p2_cmp",   is_cmp, 0);
        chk("bp_p2_ready", in_ready, 1);
        step();
        chk("bp_empty",    out_valid, 0);
        chk("bp_cnt",      issue_cnt, 3);

        // Streaming with random valid/ready against a FIFO scoreboard
        acc = 0;
        emit = 0;
        cyc = 0;
        while ((acc < 100 || emit < 100) && cyc < 3000) begin
            drive((acc < 100) && ($urandom_range(0, 3) != 0),
                  8'($urandom), 8'($urandom), 4'($urandom));
            out_ready = 1'($urandom_range(0, 1));
            if (in_valid && in_ready) begin
                sb.push_back({in_A, in_B, in_op_sel});
                acc++;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("st_spurious", 1, 0);
                end else begin
                    exp_pkt = sb.pop_front();
                    chk("st_pkt", {A, B, op_sel}, exp_pkt);
                    chk("st_cmp", is_cmp, exp_cmp(exp_pkt[3:0]));
                end
                emit++;
            end
            step();
            cyc++;
        end
        drive(1'b0, 8'h00, 8'h00, 4'h0);
        out_ready = 1'b0;
        chk("st_emitted", emit, 100);
        chk("st_cnt",     issue_cnt, 103);
        chk("st_empty",   out_valid, 0);

        // Flush with both entries full and a packet offered
        drive(1'b1, 8'hA1, 8'hB1, 4'b0111);
        step();
        drive(1'b1, 8'hA2, 8'hB2, 4'b1111);
        step();
        chk("fl_full", in_ready, 0);
        drive(1'b1, 8'hA3, 8'hB3, 4'b1001);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 4'h0);
        chk("fl_out_valid", out_valid, 0);
        chk("fl_in_ready",  in_ready, 1);
        chk("fl_is_cmp",    is_cmp, 0);
        chk("fl_cnt",       issue_cnt, 103);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fl_no_emit", out_valid, 0);
        end

        // Flush while an input handshake fires: packet discarded
        out_ready = 1'b0;
        drive(1'b1, 8'hC1, 8'hC2, 4'b1010);
        step();
        drive(1'b1, 8'hD1, 8'hD2, 4'b1011);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 4'h0);
        chk("fl2_out_valid", out_valid, 0);
        chk("fl2_in_ready",  in_ready, 1);
        out_ready = 1'b1;
        step();
        chk("fl2_no_emit",   out_valid, 0);
        chk("fl2_cnt",       issue_cnt, 103);

        // Counter wrap
        out_ready = 1'b1;
        drive(1'b1, 8'h11, 8'h22, 4'h3);
        step();
        drive(1'b0, 8'h00, 8'h00, 4'h0);
        force dut.issue_cnt_q = 16'hFFFF;
        #1;
        release dut.issue_cnt_q;
        chk("wr_pre", issue_cnt, 16'hFFFF);
        step();
        chk("wr_cnt", issue_cnt, 0);

        // Reset in the middle of backpressure
        out_ready = 1'b0;
        drive(1'b1, 8'h55, 8'h66, 4'hE);
        step();
        drive(1'b1, 8'h77, 8'h88, 4'hF);
        step();
        drive(1'b0, 8'h00, 8'h00, 4'h0);
        chk("mr_full", in_ready, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_out_valid", out_valid, 0);
        chk("mr_in_ready",  in_ready, 1);
        chk("mr_cnt",       issue_cnt, 0);
        chk("mr_A",         A, 0);
        out_ready = 1'b1;
        step();
        chk("mr_no_emit",   out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
